// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 4096x20 SRAM initiator controller.
// Encodings of pwr_mode_t / pwr_state_t match the host-visible pin values.
package sram_ctrl_pkg;

   localparam int AW_DEF      = 12;
   localparam int DW_DEF      = 20;
   localparam int TIMEOUT_DEF = 1023;

   typedef enum logic [1:0] {
      PM_ACTIVE = 2'd0,
      PM_DSLP   = 2'd1,
      PM_SD     = 2'd2,
      PM_RSVD   = 2'd3
   } pwr_mode_t;

   typedef enum logic [1:0] {
      PS_ACTIVE  = 2'd0,
      PS_DSLP    = 2'd1,
      PS_SD      = 2'd2,
      PS_TRANSIT = 2'd3
   } pwr_state_t;

   typedef enum logic [2:0] {
      ST_WAKE   = 3'd0,
      ST_ACTIVE = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_ENTER  = 3'd3,
      ST_LP     = 3'd4,
      ST_ERR    = 3'd5
   } fsm_state_t;

endpackage

// File: rtl/sram_ctrl_sync2.sv
// Two-flop synchronizer for the macro power-chain echoes; resets to 0.
module sram_ctrl_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/sram4096x20_ctrl.sv
// Initiator-side controller for the 4096x20 single-port SRAM macro:
// registered access pins, 2-cycle read return, DSLP/SD entry/exit sequencing.
module sram4096x20_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int         AW        = AW_DEF,
   parameter int         DW        = DW_DEF,
   parameter int         TIMEOUT   = TIMEOUT_DEF,
   parameter logic [1:0] RTSEL_VAL = 2'b01,
   parameter logic [1:0] WTSEL_VAL = 2'b01
) (
   input  logic          CLK,
   input  logic          RSTB,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [DW-1:0] req_bmask,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   input  logic [1:0]    pwr_mode_req,
   output logic [1:0]    pwr_state,
   output logic          pwr_err,
   output logic          SD,
   output logic          DSLP,
   output logic          CEB,
   output logic          WEB,
   output logic [AW-1:0] A,
   output logic [DW-1:0] BWEB,
   output logic [DW-1:0] D,
   input  logic [DW-1:0] Q,
   input  logic          PUDELAY_SD,
   input  logic          PUDELAY_DSLP,
   output logic [1:0]    RTSEL,
   output logic [1:0]    WTSEL
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0] pd_raw;
   logic [1:0] pd_sync;
   logic       pd_dslp_s;
   logic       pd_sd_s;

   assign pd_raw = {PUDELAY_SD, PUDELAY_DSLP};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         sram_ctrl_sync2 u_sync (
            .clk     (CLK),
            .rst_n   (RSTB),
            .async_i (pd_raw[gi]),
            .sync_o  (pd_sync[gi])
         );
      end
   endgenerate

   assign pd_dslp_s = pd_sync[0];
   assign pd_sd_s   = pd_sync[1];

   fsm_state_t    state_q, state_d;
   pwr_mode_t     mode_q, mode_d;
   pwr_mode_t     mode_req;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sd_q, sd_d;
   logic          dslp_q, dslp_d;
   logic          timed;
   logic          pd_match;

   logic          ceb_q, ceb_d;
   logic          web_q, web_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] d_q, d_d;
   logic [DW-1:0] bweb_q, bweb_d;
   logic          rd1_q, rd1_d;
   logic          rd2_q, rd2_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          accept;

   assign mode_req = pwr_mode_t'(pwr_mode_req);
   assign pd_match = (mode_q == PM_SD) ? pd_sd_s : pd_dslp_s;
   assign timed    = (state_q == ST_WAKE) || (state_q == ST_ENTER);

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      req_ready = 1'b0;
      case (state_q)
         ST_WAKE: begin
            if (!pd_sd_s && !pd_dslp_s)       state_d = ST_ACTIVE;
            else if (cnt_q == CW'(TIMEOUT))   state_d = ST_ERR;
         end
         ST_ACTIVE: begin
            // Target mode is captured here so DRAIN/ENTER see a stable value.
            if (mode_req == PM_DSLP || mode_req == PM_SD) begin
               state_d = ST_DRAIN;
               mode_d  = mode_req;
            end else begin
               req_ready = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!rd1_q && !rd2_q) state_d = ST_ENTER;
         end
         ST_ENTER: begin
            if (pd_match)                     state_d = ST_LP;
            else if (cnt_q == CW'(TIMEOUT))   state_d = ST_ERR;
         end
         ST_LP: begin
            if (mode_req != mode_q) state_d = ST_WAKE;
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase

      if (state_d != state_q || !timed) cnt_d = '0;
      else                              cnt_d = cnt_q + CW'(1);

      // Pins follow the next state so they change on the same edge as the FSM.
      sd_d   = (state_d == ST_ERR) ||
               ((state_d == ST_ENTER || state_d == ST_LP) && mode_d == PM_SD);
      dslp_d = (state_d == ST_ENTER || state_d == ST_LP) && mode_d == PM_DSLP;
   end

   assign accept = req_valid && req_ready;

   always_comb begin
      ceb_d       = !accept;
      web_d       = accept ? !req_we : 1'b1;
      a_d         = accept ? req_addr : a_q;
      d_d         = (accept && req_we) ? req_wdata : d_q;
      bweb_d      = (accept && req_we) ? ~req_bmask : '1;
      rd1_d       = accept && !req_we;
      rd2_d       = rd1_q;
      rsp_valid_d = rd2_q;
      rsp_rdata_d = rd2_q ? Q : rsp_rdata_q;
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= ST_WAKE;
         mode_q      <= PM_ACTIVE;
         cnt_q       <= '0;
         sd_q        <= 1'b0;
         dslp_q      <= 1'b0;
         ceb_q       <= 1'b1;
         web_q       <= 1'b1;
         a_q         <= '0;
         d_q         <= '0;
         bweb_q      <= '1;
         rd1_q       <= 1'b0;
         rd2_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         sd_q        <= sd_d;
         dslp_q      <= dslp_d;
         ceb_q       <= ceb_d;
         web_q       <= web_d;
         a_q         <= a_d;
         d_q         <= d_d;
         bweb_q      <= bweb_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_ACTIVE: pwr_state = PS_ACTIVE;
         ST_LP:     pwr_state = mode_q;
         ST_ERR:    pwr_state = PS_SD;
         default:   pwr_state = PS_TRANSIT;
      endcase
   end

   assign pwr_err   = (state_q == ST_ERR);
   assign SD        = sd_q;
   assign DSLP      = dslp_q;
   assign CEB       = ceb_q;
   assign WEB       = web_q;
   assign A         = a_q;
   assign D         = d_q;
   assign BWEB      = bweb_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign RTSEL     = RTSEL_VAL;
   assign WTSEL     = WTSEL_VAL;

endmodule

// File: tb/tb_sram4096x20_ctrl.sv
// Directed bench for sram4096x20_ctrl with a behavioural macro model.
module tb_sram4096x20_ctrl;

   localparam int AW = 12;
   localparam int DW = 20;
   localparam int TO = 1023;
   localparam int NV = 12;

   logic          CLK;
   logic          RSTB;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] req_bmask;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    pwr_mode_req;
   logic [1:0]    pwr_state;
   logic          pwr_err;
   logic          SD, DSLP, CEB, WEB;
   logic [AW-1:0] A;
   logic [DW-1:0] BWEB, D, Q;
   logic          PUDELAY_SD, PUDELAY_DSLP;
   logic [1:0]    RTSEL, WTSEL;

   int total;
   int bad;

   sram4096x20_ctrl dut (
      .CLK(CLK), .RSTB(RSTB),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .pwr_mode_req(pwr_mode_req), .pwr_state(pwr_state), .pwr_err(pwr_err),
      .SD(SD), .DSLP(DSLP), .CEB(CEB), .WEB(WEB), .A(A), .BWEB(BWEB), .D(D), .Q(Q),
      .PUDELAY_SD(PUDELAY_SD), .PUDELAY_DSLP(PUDELAY_DSLP),
      .RTSEL(RTSEL), .WTSEL(WTSEL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Macro model: samples pins on the rising edge, Q valid after that edge.
   logic [DW-1:0] mem [0:4095];
   always @(posedge CLK) begin
      if (!CEB) begin
         if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
         else      Q <= mem[A];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input string nm);
      int c;
      c = 0;
      while (pwr_state !== s && c < 50) begin
         @(negedge CLK);
         c++;
      end
      chk(nm, {30'd0, pwr_state}, {30'd0, s});
   endtask

   typedef struct {
      logic          vld;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] bmask;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [NV];

   initial begin
      int  cyc;
      int  idx;
      logic ev;
      logic got;
      logic [DW-1:0] gdat;

      vecs[0]  = '{1'b1, 1'b1, 12'h0A5, 20'hABCDE, 20'hFFFFF, 20'h0};
      vecs[1]  = '{1'b1, 1'b0, 12'h0A5, 20'h0,     20'h0,     20'hABCDE};
      vecs[2]  = '{1'b1, 1'b1, 12'h000, 20'h12345, 20'hFFFFF, 20'h0};
      vecs[3]  = '{1'b1, 1'b1, 12'hFFF, 20'h5A5A5, 20'hFFFFF, 20'h0};
      vecs[4]  = '{1'b1, 1'b1, 12'h800, 20'hFFFFF, 20'hFFFFF, 20'h0};
      vecs[5]  = '{1'b1, 1'b1, 12'h800, 20'h00000, 20'h000FF, 20'h0};
      vecs[6]  = '{1'b1, 1'b0, 12'h000, 20'h0,     20'h0,     20'h12345};
      vecs[7]  = '{1'b1, 1'b0, 12'hFFF, 20'h0,     20'h0,     20'h5A5A5};
      vecs[8]  = '{1'b1, 1'b0, 12'h800, 20'h0,     20'h0,     20'hFFF00};
      vecs[9]  = '{1'b0, 1'b0, 12'h000, 20'h0,     20'h0,     20'h0};
      vecs[10] = '{1'b1, 1'b1, 12'h0A5, 20'h00000, 20'hF0000, 20'h0};
      vecs[11] = '{1'b1, 1'b0, 12'h0A5, 20'h0,     20'h0,     20'h0BCDE};

      total = 0;
      bad   = 0;
      RSTB = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_bmask = '0;
      pwr_mode_req = 2'd0;
      PUDELAY_SD = 1'b0; PUDELAY_DSLP = 1'b0;

      // Reset values
      @(negedge CLK);
      chk("rst_ceb", {31'd0, CEB}, 32'd1);
      chk("rst_web", {31'd0, WEB}, 32'd1);
      chk("rst_sd", {31'd0, SD}, 32'd0);
      chk("rst_dslp", {31'd0, DSLP}, 32'd0);
      chk("rst_a", {20'd0, A}, 32'd0);
      chk("rst_bweb", {12'd0, BWEB}, 32'hFFFFF);
      chk("rst_d", {12'd0, D}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", {12'd0, rsp_rdata}, 32'd0);
      chk("rst_pstate", {30'd0, pwr_state}, 32'd3);
      chk("rst_err", {31'd0, pwr_err}, 32'd0);
      chk("rtsel", {30'd0, RTSEL}, 32'd1);
      chk("wtsel", {30'd0, WTSEL}, 32'd1);
      $display("reset applied");

      @(negedge CLK);
      RSTB = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("wake_pstate", {30'd0, pwr_state}, 32'd0);
      chk("wake_ready", {31'd0, req_ready}, 32'd1);
      chk("wake_ceb", {31'd0, CEB}, 32'd1);
      $display("reset released, pwr_state=%0d", pwr_state);

      // Back-to-back access table; response expected 3 negedges after drive.
      for (int n = 0; n < NV + 3; n++) begin
         if (n > 0) @(negedge CLK);
         if (n >= 1) begin
            idx = n - 1;
            ev = (idx < NV) ? vecs[idx].vld : 1'b0;
            chk($sformatf("ceb_%0d", idx), {31'd0, CEB}, {31'd0, !ev});
            if (ev) begin
               chk($sformatf("web_%0d", idx), {31'd0, WEB}, {31'd0, !vecs[idx].we});
               chk($sformatf("addr_%0d", idx), {20'd0, A}, {20'd0, vecs[idx].addr});
               if (vecs[idx].we) begin
                  chk($sformatf("bweb_%0d", idx), {12'd0, BWEB}, {12'd0, ~vecs[idx].bmask});
                  chk($sformatf("d_%0d", idx), {12'd0, D}, {12'd0, vecs[idx].wdata});
               end else begin
                  chk($sformatf("bweb_%0d", idx), {12'd0, BWEB}, 32'hFFFFF);
               end
            end
         end
         idx = n - 3;
         ev = (idx >= 0 && idx < NV) ? (vecs[idx].vld && !vecs[idx].we) : 1'b0;
         chk($sformatf("rspv_%0d", n), {31'd0, rsp_valid}, {31'd0, ev});
         if (ev) begin
            chk($sformatf("rdata_%0d", idx), {12'd0, rsp_rdata}, {12'd0, vecs[idx].exp});
            $display("rsp  vec=%0d rdata=%h", idx, rsp_rdata);
         end
         if (n < NV) begin
            req_valid = vecs[n].vld;
            req_we    = vecs[n].we;
            req_addr  = vecs[n].addr;
            req_wdata = vecs[n].wdata;
            req_bmask = vecs[n].bmask;
            #1;
            if (vecs[n].vld) chk($sformatf("ready_%0d", n), {31'd0, req_ready}, 32'd1);
            $display("req  vec=%0d vld=%0b we=%0b addr=%h wdata=%h bmask=%h",
                     n, vecs[n].vld, vecs[n].we, vecs[n].addr, vecs[n].wdata, vecs[n].bmask);
         end else begin
            req_valid = 1'b0;
         end
      end

      // Deep-sleep request while a read is in flight
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h0A5;
      @(negedge CLK);
      chk("dslp_rd_ceb", {31'd0, CEB}, 32'd0);
      req_valid = 1'b0;
      pwr_mode_req = 2'd1;
      #1;
      chk("dslp_ready0", {31'd0, req_ready}, 32'd0);
      got = 1'b0; gdat = '0; cyc = 0;
      while (DSLP !== 1'b1 && cyc < 20) begin
         @(negedge CLK);
         cyc++;
         if (rsp_valid) begin
            got = 1'b1;
            gdat = rsp_rdata;
         end
      end
      chk("dslp_enter", {31'd0, DSLP}, 32'd1);
      chk("dslp_rsp_seen", {31'd0, got}, 32'd1);
      chk("dslp_rsp_data", {12'd0, gdat}, 32'h0BCDE);
      chk("dslp_enter_pstate", {30'd0, pwr_state}, 32'd3);
      chk("dslp_enter_sd", {31'd0, SD}, 32'd0);
      $display("dslp entry, in-flight rdata=%h", gdat);
      PUDELAY_DSLP = 1'b1;
      wait_state(2'd1, "dslp_lp_pstate");
      chk("dslp_lp_pin", {31'd0, DSLP}, 32'd1);
      chk("dslp_lp_ready", {31'd0, req_ready}, 32'd0);
      pwr_mode_req = 2'd0;
      @(negedge CLK);
      chk("dslp_exit_pin", {31'd0, DSLP}, 32'd0);
      chk("dslp_exit_pstate", {30'd0, pwr_state}, 32'd3);
      @(negedge CLK);
      PUDELAY_DSLP = 1'b0;
      wait_state(2'd0, "dslp_back_active");
      chk("dslp_back_ready", {31'd0, req_ready}, 32'd1);
      $display("dslp exit, pwr_state=%0d", pwr_state);

      // Request and mode change together: not accepted
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h123;
      pwr_mode_req = 2'd2;
      #1;
      chk("simul_ready", {31'd0, req_ready}, 32'd0);
      @(negedge CLK);
      chk("simul_ceb", {31'd0, CEB}, 32'd1);
      req_valid = 1'b0;
      $display("simultaneous req+mode change, ceb=%0b", CEB);

      // Shutdown with PUDELAY_SD stuck low -> timeout
      cyc = 0;
      while (SD !== 1'b1 && cyc < 20) begin
         @(negedge CLK);
         cyc++;
      end
      chk("sd_enter", {31'd0, SD}, 32'd1);
      chk("sd_enter_err", {31'd0, pwr_err}, 32'd0);
      chk("sd_enter_pstate", {30'd0, pwr_state}, 32'd3);
      cyc = 0;
      while (pwr_err !== 1'b1 && cyc < TO + 100) begin
         @(negedge CLK);
         cyc++;
      end
      chk("sd_timeout_err", {31'd0, pwr_err}, 32'd1);
      chk("sd_timeout_window", {31'd0, (cyc >= TO && cyc <= TO + 2)}, 32'd1);
      chk("err_pstate", {30'd0, pwr_state}, 32'd2);
      chk("err_sd", {31'd0, SD}, 32'd1);
      chk("err_dslp", {31'd0, DSLP}, 32'd0);
      $display("sd timeout after %0d cycles, pwr_err=%0b", cyc, pwr_err);
      pwr_mode_req = 2'd0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h001;
      repeat (4) begin
         @(negedge CLK);
         chk("err_ready", {31'd0, req_ready}, 32'd0);
         chk("err_ceb", {31'd0, CEB}, 32'd1);
      end
      chk("err_sticky", {31'd0, pwr_err}, 32'd1);
      req_valid = 1'b0;

      // Reset recovers; then reset in the middle of a read
      RSTB = 1'b0;
      #1;
      chk("err_rst_clear", {31'd0, pwr_err}, 32'd0);
      chk("err_rst_sd", {31'd0, SD}, 32'd0);
      @(negedge CLK);
      RSTB = 1'b1;
      wait_state(2'd0, "rerst_active");
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFF;
      @(negedge CLK);
      req_valid = 1'b0;
      chk("midrst_ceb_lo", {31'd0, CEB}, 32'd0);
      RSTB = 1'b0;
      #1;
      chk("midrst_ceb_hi", {31'd0, CEB}, 32'd1);
      @(negedge CLK);
      RSTB = 1'b1;
      got = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         if (rsp_valid) got = 1'b1;
      end
      chk("midrst_no_rsp", {31'd0, got}, 32'd0);
      $display("mid-read reset, rsp seen=%0b", got);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
